uart_pkt_rx: RTL and testbench

Framed-packet receiver that sits directly downstream of the UART top level's receive FIFO. It pulls bytes through the FIFO read port, hunts for a sync byte, and parses length, payload and checksum. Verified payloads are buffered and then streamed to the consumer over a valid/ready interface. Malformed, corrupt or stalled frames are dropped and reported with single-cycle error pulses.

---
 rtl/uart_pkt_pkg.sv | 21 ++
 rtl/uart_pkt_rx_if.sv | 23 ++
 rtl/uart_pkt_buf.sv | 38 +++
 rtl/uart_pkt_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_pkt_rx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the framed-packet UART receiver.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } pkt_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CHK_W         = 8;

  // Frame checksum accumulates with 8-bit wraparound.
  function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] a,
                                               input logic [CHK_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_pkt_rx_if.sv
// RX FIFO read port and payload stream of the packet receiver.
interface uart_pkt_rx_if #(
  parameter int LEN_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_empty;
  logic             rx_rd_en;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             pkt_ready;
  logic             pkt_last;
  logic [LEN_W-1:0] pkt_len;

  modport master (
    input  rx_data, rx_empty, pkt_ready,
    output rx_rd_en, pkt_data, pkt_valid, pkt_last, pkt_len
  );

  modport slave (
    output rx_data, rx_empty, pkt_ready,
    input  rx_rd_en, pkt_data, pkt_valid, pkt_last, pkt_len
  );
endinterface

// File: rtl/uart_pkt_buf.sv
// MAX_LEN x 8 payload register file: synchronous write, combinational read.
module uart_pkt_buf #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0] mem_r [MAX_LEN];

  // Payload storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_en && (wr_addr < LEN_W'(MAX_LEN))) begin
      mem_r[wr_addr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // The drain look-ahead address runs one past the frame end; read zero there.
  always_comb begin
    if (rd_addr < LEN_W'(MAX_LEN)) begin
      rd_data = mem_r[rd_addr[ADDR_W-1:0]];
    end else begin
      rd_data = 8'h00;
    end
  end

endmodule

// File: rtl/uart_pkt_rx.sv
// Framed-packet receiver: SYNC, LEN, payload, CHK pulled from the RX FIFO.
// Optional inter-byte timeout is built only when PKT_TIMEOUT_EN is defined.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_pkt_rx_if.master bus,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_timeout,
  output logic          busy
);
  localparam int         LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  pkt_state_e       state_r, state_nxt;
  logic             pend_r;
  logic             rd_en_s;
  logic [LEN_W-1:0] len_r, len_nxt;
  logic [LEN_W-1:0] idx_r, idx_nxt;
  logic [LEN_W-1:0] pkt_len_r, pkt_len_nxt;
  logic [CHK_W-1:0] sum_r, sum_nxt;
  logic [7:0]       pkt_data_r, pkt_data_nxt;
  logic             pkt_valid_r, pkt_valid_nxt;
  logic             pkt_last_r, pkt_last_nxt;
  logic             err_chk_r, err_chk_nxt;
  logic             err_len_r, err_len_nxt;
  logic             busy_r;
  logic             buf_we_s;
  logic [LEN_W-1:0] buf_raddr_s;
  logic [7:0]       buf_rdata_s;
  logic             timeout_s;

  // Reads stop during DRAIN so the next frame waits in the FIFO.
  assign rd_en_s = !bus.rx_empty && !pend_r && (state_r != DRAIN);

  // Look one byte ahead while draining so pkt_data can be registered.
  assign buf_raddr_s = (state_r == DRAIN) ? (idx_r + LEN_W'(1)) : LEN_W'(0);

  uart_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_we_s),
    .wr_addr (idx_r),
    .wr_data (bus.rx_data),
    .rd_addr (buf_raddr_s),
    .rd_data (buf_rdata_s)
  );

`ifdef PKT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_r;
  logic            to_run_s;
  logic            err_to_r;

  assign to_run_s  = (state_r == LEN) || (state_r == PAYLOAD) || (state_r == CHK);
  assign timeout_s = to_run_s && !pend_r && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter; a capture cycle restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
      err_to_r <= 1'b0;
    end else begin
      err_to_r <= timeout_s;
      if (!to_run_s || pend_r || timeout_s) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  assign err_timeout = err_to_r;
`else
  assign timeout_s   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state and output decode; pend_r marks the cycle rx_data holds a fresh byte.
  always_comb begin
    state_nxt     = state_r;
    len_nxt       = len_r;
    idx_nxt       = idx_r;
    sum_nxt       = sum_r;
    pkt_len_nxt   = pkt_len_r;
    pkt_data_nxt  = pkt_data_r;
    pkt_valid_nxt = pkt_valid_r;
    pkt_last_nxt  = pkt_last_r;
    err_chk_nxt   = 1'b0;
    err_len_nxt   = 1'b0;
    buf_we_s      = 1'b0;

    case (state_r)
      HUNT: begin
        if (pend_r && (bus.rx_data == SYNC_BYTE)) begin
          state_nxt = LEN;
        end else begin
          state_nxt = HUNT;
        end
      end

      LEN: begin
        if (pend_r) begin
          if ((bus.rx_data == 8'h00) || (bus.rx_data > MAX_LEN_B)) begin
            err_len_nxt = 1'b1;
            state_nxt   = HUNT;
          end else begin
            len_nxt   = bus.rx_data[LEN_W-1:0];
            sum_nxt   = bus.rx_data;
            idx_nxt   = LEN_W'(0);
            state_nxt = PAYLOAD;
          end
        end else if (timeout_s) begin
          state_nxt = HUNT;
        end else begin
          state_nxt = LEN;
        end
      end

      PAYLOAD: begin
        if (pend_r) begin
          buf_we_s = 1'b1;
          sum_nxt  = chk_add(sum_r, bus.rx_data);
          if (idx_r == (len_r - LEN_W'(1))) begin
            state_nxt = CHK;
          end else begin
            idx_nxt = idx_r + LEN_W'(1);
          end
        end else if (timeout_s) begin
          state_nxt = HUNT;
        end else begin
          state_nxt = PAYLOAD;
        end
      end

      CHK: begin
        if (pend_r) begin
          if (bus.rx_data == sum_r) begin
            state_nxt     = DRAIN;
            idx_nxt       = LEN_W'(0);
            pkt_len_nxt   = len_r;
            pkt_data_nxt  = buf_rdata_s;
            pkt_valid_nxt = 1'b1;
            pkt_last_nxt  = (len_r == LEN_W'(1));
          end else begin
            err_chk_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end else if (timeout_s) begin
          state_nxt = HUNT;
        end else begin
          state_nxt = CHK;
        end
      end

      DRAIN: begin
        if (bus.pkt_ready) begin
          if (pkt_last_r) begin
            pkt_valid_nxt = 1'b0;
            pkt_last_nxt  = 1'b0;
            idx_nxt       = LEN_W'(0);
            state_nxt     = HUNT;
          end else begin
            idx_nxt      = idx_r + LEN_W'(1);
            pkt_data_nxt = buf_rdata_s;
            pkt_last_nxt = ((idx_r + LEN_W'(2)) == len_r);
          end
        end else begin
          state_nxt = DRAIN;
        end
      end

      default: begin
        state_nxt     = HUNT;
        pkt_valid_nxt = 1'b0;
        pkt_last_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      pend_r      <= 1'b0;
      len_r       <= '0;
      idx_r       <= '0;
      sum_r       <= '0;
      pkt_len_r   <= '0;
      pkt_data_r  <= 8'h00;
      pkt_valid_r <= 1'b0;
      pkt_last_r  <= 1'b0;
      err_chk_r   <= 1'b0;
      err_len_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      pend_r      <= rd_en_s;
      len_r       <= len_nxt;
      idx_r       <= idx_nxt;
      sum_r       <= sum_nxt;
      pkt_len_r   <= pkt_len_nxt;
      pkt_data_r  <= pkt_data_nxt;
      pkt_valid_r <= pkt_valid_nxt;
      pkt_last_r  <= pkt_last_nxt;
      err_chk_r   <= err_chk_nxt;
      err_len_r   <= err_len_nxt;
      busy_r      <= (state_nxt != HUNT);
    end
  end

  assign bus.rx_rd_en  = rd_en_s;
  assign bus.pkt_data  = pkt_data_r;
  assign bus.pkt_valid = pkt_valid_r;
  assign bus.pkt_last  = pkt_last_r;
  assign bus.pkt_len   = pkt_len_r;
  assign err_chk       = err_chk_r;
  assign err_len       = err_len_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: frame-level reference model, FIFO model, per-cycle compare.
module tb_uart_pkt_rx;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int TO_CYC  = 100;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_chk, err_len, err_timeout, busy;

  uart_pkt_rx_if #(.LEN_W(LEN_W)) bus();

  uart_pkt_rx #(
    .MAX_LEN        (MAX_LEN),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_bytes [$];
  int         exp_lens [$];
  int         exp_pos = 0;
  int         exp_chk = 0, exp_len = 0, exp_to = 0;
  int         obs_chk = 0, obs_len = 0, obs_to = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [LEN_W-1:0] prev_len;
  logic       prev_echk = 1'b0, prev_elen = 1'b0, prev_eto = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: scan the byte stream and list good payloads and errors.
  task automatic model_feed(input bq_t b);
    int i, n, l, s;
    i = 0;
    n = b.size();
    while (i < n) begin
      if (b[i] != 8'hA5) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        l = int'(b[i+1]);
        if (l == 0 || l > MAX_LEN) begin
          exp_len++;
          i += 2;
        end else if (i + 2 + l >= n) begin
          i = n;
        end else begin
          s = l;
          for (int k = 0; k < l; k++) s += int'(b[i+2+k]);
          if (b[i+2+l] == 8'(s)) begin
            for (int k = 0; k < l; k++) exp_bytes.push_back(b[i+2+k]);
            exp_lens.push_back(l);
          end else begin
            exp_chk++;
          end
          i += 3 + l;
        end
      end
    end
  endtask

  task automatic send(input bq_t b);
    model_feed(b);
    foreach (b[i]) fifo_q.push_back(b[i]);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (k < 3000 && !(fifo_q.size() == 0 && !busy && exp_bytes.size() == 0 && !bus.pkt_valid)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle: got busy after %0d cycles expected idle", name, k);
    end
    repeat (4) @(negedge clk);
    check({name, "_err_chk"}, obs_chk, exp_chk);
    check({name, "_err_len"}, obs_len, exp_len);
    check({name, "_err_to"},  obs_to,  exp_to);
  endtask

  // RX FIFO model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rst_n && bus.rx_rd_en) begin
      if (fifo_q.size() > 0) begin
        bus.rx_data <= fifo_q.pop_front();
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_on_empty: got rx_rd_en 1 expected 0");
      end
    end
  end

  always @(negedge clk) bus.rx_empty <= (fifo_q.size() == 0);

  // Per-cycle compare of the stream and error pulses against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pkt_valid) begin
        if (exp_bytes.size() == 0) begin
          check("unexpected_valid", {31'd0, bus.pkt_valid}, 32'd0);
        end else begin
          check("pkt_data", bus.pkt_data, exp_bytes[0]);
          check("pkt_last", {31'd0, bus.pkt_last}, {31'd0, (exp_pos == exp_lens[0] - 1)});
          check("pkt_len",  bus.pkt_len, exp_lens[0]);
          check("rd_in_drain", {31'd0, bus.rx_rd_en}, 32'd0);
          if (prev_stall) begin
            check("stall_data", bus.pkt_data, prev_data);
            check("stall_last", {31'd0, bus.pkt_last}, {31'd0, prev_last});
            check("stall_len",  bus.pkt_len, prev_len);
          end
          if (bus.pkt_ready) begin
            void'(exp_bytes.pop_front());
            exp_pos++;
            if (exp_pos == exp_lens[0]) begin
              void'(exp_lens.pop_front());
              exp_pos = 0;
            end
          end
        end
      end
      prev_stall = bus.pkt_valid && !bus.pkt_ready;
      prev_data  = bus.pkt_data;
      prev_last  = bus.pkt_last;
      prev_len   = bus.pkt_len;
      if (err_chk) obs_chk++;
      if (err_len) obs_len++;
      if (err_timeout) obs_to++;
      if (err_chk && prev_echk) check("err_chk_width", 32'd2, 32'd1);
      if (err_len && prev_elen) check("err_len_width", 32'd2, 32'd1);
      if (err_timeout && prev_eto) check("err_to_width", 32'd2, 32'd1);
      prev_echk = err_chk;
      prev_elen = err_len;
      prev_eto  = err_timeout;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    bus.pkt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rd_en",  {31'd0, bus.rx_rd_en},  32'd0);
    check("rst_valid",  {31'd0, bus.pkt_valid}, 32'd0);
    check("rst_last",   {31'd0, bus.pkt_last},  32'd0);
    check("rst_data",   bus.pkt_data, 32'd0);
    check("rst_len",    bus.pkt_len,  32'd0);
    check("rst_errs",   {29'd0, err_chk, err_len, err_timeout}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    check("model_good_n",   exp_lens.size(), 32'd1);
    check("model_good_len", exp_lens[0], 32'd3);
    check("model_good_b2",  exp_bytes[2], 32'h33);
    wait_idle("good");

    send('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    check("model_badchk", exp_chk, 32'd1);
    send('{8'hA5, 8'h01, 8'h7E, 8'h7F});
    wait_idle("badchk");

    send('{8'hA5, 8'h00, 8'hA5, 8'h11});
    check("model_badlen", exp_len, 32'd2);
    send('{8'hA5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h98});
    check("model_max_len", exp_lens[0], 32'd16);
    wait_idle("lenbounds");

    send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    check("model_hunt", exp_bytes.size(), 32'd1);
    wait_idle("hunt");

    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    j = 0;
    while (!bus.pkt_valid && j < 200) begin
      @(negedge clk);
      j++;
    end
    check("bp_drain_seen", {31'd0, bus.pkt_valid}, 32'd1);
    @(posedge clk); #1 bus.pkt_ready = 1'b0;
    repeat (10) @(posedge clk);
    check("bp_fifo_held", fifo_q.size(), 32'd4);
    #1 bus.pkt_ready = 1'b1;
    wait_idle("backpressure");

    send('{8'hA5, 8'h02, 8'h10});
    j = 0;
    while (fifo_q.size() != 0 && j < 200) begin
      @(negedge clk);
      j++;
    end
`ifdef PKT_TIMEOUT_EN
    j = 0;
    while (!err_timeout && j < 400) begin
      @(negedge clk);
      j++;
    end
    exp_to = 1;
    check("timeout_latency", j - 1, TO_CYC);
    @(negedge clk);
    check("timeout_hunt", {31'd0, busy}, 32'd0);
    send('{8'hA5, 8'h01, 8'h7E, 8'h7F});
    wait_idle("timeout");
`else
    repeat (300) @(negedge clk);
    check("stuck_busy", {31'd0, busy}, 32'd1);
    check("stuck_no_err", obs_chk + obs_len + obs_to, exp_chk + exp_len);
`endif

    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, bus.pkt_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send('{8'hA5, 8'h01, 8'h7E, 8'h7F});
    wait_idle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
